// File: rtl/nibbler_prog_loader.sv
// nibbler_prog_loader: streams program bytes into uP program memory from address 0 while holding the uP in reset
module nibbler_prog_loader #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  input  logic              end_load,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic [ADDR_W:0]   byte_count,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, LOAD, RELEASE} state_t;
  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(MAX_BYTES);
  state_t state, state_nx;
  logic hs;
  always_comb begin
    state_nx   = (state == IDLE) ? (start ? LOAD : IDLE) :
                 (state == LOAD) ? (end_load ? RELEASE : LOAD) : IDLE;
    byte_ready = (state == LOAD) && (byte_count < CAP);
    hs         = byte_valid && byte_ready;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // byte_count doubles as the write pointer; the cap keeps it from ever wrapping the address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_count <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      cpu_reset  <= 1'b1;
    end else begin
      mem_we    <= hs;
      busy      <= state_nx != IDLE;
      cpu_reset <= state_nx != IDLE;
      if (hs) begin
        mem_addr   <= byte_count[ADDR_W-1:0];
        mem_wdata  <= byte_data;
        byte_count <= byte_count + (ADDR_W+1)'(1);
      end
      if (state == IDLE && start) begin
        byte_count <= '0;
        overflow   <= 1'b0;
      end else if (state == LOAD && byte_valid && !byte_ready) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_nibbler_prog_loader.sv
// tb_nibbler_prog_loader: directed sessions checked every cycle against a session-level model plus literal spot checks
module tb_nibbler_prog_loader;
  localparam int MAX = 4;
  logic clk = 0, reset = 1, start = 0, byte_valid = 0, end_load = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, mem_we, cpu_reset, busy, overflow;
  logic [11:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [12:0] byte_count;
  int vectors = 0, miscompares = 0;

  nibbler_prog_loader #(.ADDR_W(12), .DATA_W(8), .MAX_BYTES(MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .end_load(end_load), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .busy(busy), .byte_count(byte_count),
    .overflow(overflow));

  always #5 clk = ~clk;

  // session model: phase 0 idle, 1 loading, 2 releasing; q holds the bytes accepted this session
  int m_phase = 0;
  logic [7:0] q[$];
  bit m_ovf = 0, m_we = 0, m_cpu = 1;
  int m_addr = 0, m_data = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; q.delete(); m_ovf = 0; m_we = 0; m_addr = 0; m_data = 0; m_cpu = 1;
    end else begin
      m_we = 0;
      if (m_phase == 0) begin
        m_cpu = 0;
        if (start) begin m_phase = 1; q.delete(); m_ovf = 0; m_cpu = 1; end
      end else if (m_phase == 1) begin
        if (byte_valid) begin
          if (q.size() < MAX) begin
            q.push_back(byte_data); m_we = 1; m_addr = q.size() - 1; m_data = byte_data;
          end else m_ovf = 1;
        end
        if (end_load) m_phase = 2;
      end else begin
        m_phase = 0; m_cpu = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("byte_ready", 32'(byte_ready), 32'(m_phase == 1 && q.size() < MAX));
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_addr", 32'(mem_addr), m_addr);
    chk("mem_wdata", 32'(mem_wdata), m_data);
    chk("cpu_reset", 32'(cpu_reset), 32'(m_cpu));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("byte_count", 32'(byte_count), q.size());
    chk("overflow", 32'(overflow), 32'(m_ovf));
  end

  logic [11:0] wa[$];
  logic [7:0] wd[$];
  always @(negedge clk) if (mem_we === 1'b1) begin wa.push_back(mem_addr); wd.push_back(mem_wdata); end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic offer(input logic v, input logic [7:0] d, input logic e);
    byte_valid = v; byte_data = d; end_load = e; cyc();
  endtask

  initial begin
    cyc(2);
    reset = 0;
    chk("lit_rst_cpu", 32'(cpu_reset), 1);
    chk("lit_rst_busy", 32'(busy), 0);
    chk("lit_rst_count", 32'(byte_count), 0);
    cyc();
    chk("lit_idle_cpu", 32'(cpu_reset), 0);
    // valid bytes in IDLE must be ignored
    byte_valid = 1; byte_data = 8'hAA;
    cyc(5);
    byte_valid = 0;
    chk("lit_idle_writes", wa.size(), 0);
    chk("lit_idle_count", 32'(byte_count), 0);
    // three back-to-back bytes
    start = 1; cyc(); start = 0;
    chk("lit_load_cpu", 32'(cpu_reset), 1);
    offer(1, 8'h19, 0);
    chk("lit_w0", {mem_we, 3'b0, mem_addr, 8'h0, mem_wdata}, {1'b1, 3'b0, 12'd0, 8'h0, 8'h19});
    offer(1, 8'h40, 0);
    offer(1, 8'h50, 0);
    chk("lit_w2", {mem_we, 3'b0, mem_addr, 8'h0, mem_wdata}, {1'b1, 3'b0, 12'd2, 8'h0, 8'h50});
    offer(0, 8'h00, 1);
    end_load = 0;
    chk("lit_rel_cpu", 32'(cpu_reset), 1);
    cyc();
    chk("lit_end_cpu", 32'(cpu_reset), 0);
    chk("lit_end_count", 32'(byte_count), 3);
    chk("lit_log_n", wa.size(), 3);
    for (int i = 0; i < 3 && i < wa.size(); i++) chk("lit_log_addr", 32'(wa[i]), i);
    if (wd.size() >= 3) chk("lit_log_data", {8'h0, wd[0], wd[1], wd[2]}, 32'h00194050);
    // overflow with MAX=4
    wa.delete(); wd.delete();
    start = 1; cyc(); start = 0;
    for (int i = 1; i <= 5; i++) begin
      offer(1, 8'hA0 + 8'(i), 0);
      if (i == 4) chk("lit_full_ready", 32'(byte_ready), 0);
    end
    chk("lit_ovf", 32'(overflow), 1);
    chk("lit_ovf_count", 32'(byte_count), 4);
    offer(0, 8'h00, 1);
    end_load = 0;
    chk("lit_ovf_rel", 32'(overflow), 1);
    cyc();
    chk("lit_ovf_idle", 32'(overflow), 1);
    chk("lit_ovf_log_n", wa.size(), 4);
    if (wa.size() >= 4) chk("lit_ovf_last", {20'h0, wa[3]}, 3);
    start = 1; cyc(); start = 0;
    chk("lit_ovf_clear", {31'(byte_count), overflow}, 0);
    // end_load coincident with second handshake
    offer(1, 8'h11, 0);
    offer(1, 8'h3C, 1);
    chk("lit_end_hs", {mem_we, 3'b0, mem_addr, 8'h0, mem_wdata}, {1'b1, 3'b0, 12'd1, 8'h0, 8'h3C});
    chk("lit_end_hs_cnt", 32'(byte_count), 2);
    offer(0, 8'h00, 0);
    cyc();
    // asynchronous reset mid-session
    start = 1; cyc(); start = 0;
    offer(1, 8'h55, 0);
    offer(1, 8'h66, 0);
    byte_valid = 0;
    #2 reset = 1;
    #1;
    chk("lit_arst", {busy, mem_we, cpu_reset, 16'(byte_count)}, {1'b0, 1'b0, 1'b1, 16'd0});
    cyc();
    reset = 0;
    chk("lit_arst_hold", 32'(cpu_reset), 1);
    cyc();
    chk("lit_arst_rel", 32'(cpu_reset), 0);
    start = 1; cyc(); start = 0;
    offer(1, 8'h77, 0);
    chk("lit_restart", {mem_we, 3'b0, mem_addr, 8'h0, mem_wdata}, {1'b1, 3'b0, 12'd0, 8'h0, 8'h77});
    offer(0, 8'h00, 1);
    end_load = 0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
